des_iter_core: RTL and testbench

- Iterative, handshaked DES engine that performs encryption or decryption of one 64-bit block per transaction.
- Executes ROUNDS_PER_CYCLE Feistel rounds per clock, so the same RTL spans the area/latency range from fully serial (1 round per clock) to one-cycle (16 rounds per clock).
- Reuses the existing combinational f, IP, IP_inv, PC1 and PC2 modules.
- Sits between a block source (valid/ready) and a block sink (valid/ready).

---
 rtl/des_pkg.sv | 74 +++++++
 rtl/des_prims.sv | 79 +++++++
 rtl/des_round.sv | 29 ++
 rtl/des_iter_core.sv | 112 +++++++++++
 tb/tb_des_iter_core.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// Shared DES types, constant tables and key-schedule helpers.
package des_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam int unsigned DES_ROUNDS = 16;

    // Per-round rotation of C/D, indexed by round number 1..16
    localparam logic [1:0] SHIFT_ENC [1:16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                                2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    localparam logic [1:0] SHIFT_DEC [1:16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                                2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    // Permutation tables use DES 1-based bit numbering (bit 1 = MSB)
    localparam int unsigned IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int unsigned FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int unsigned E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int unsigned P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // S-box rows indexed {box, row}; column 0 is the top nibble
    localparam logic [63:0] SBOX [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] amt,
                                          input logic right);
        logic [27:0] y;
        case ({right, amt})
            3'b001:  y = {x[26:0], x[27]};
            3'b010:  y = {x[25:0], x[27:26]};
            3'b101:  y = {x[0], x[27:1]};
            3'b110:  y = {x[1:0], x[27:2]};
            default: y = x;
        endcase
        return y;
    endfunction

    function automatic int unsigned shift_total(input logic decrypt);
        int unsigned sum = 0;
        for (int n = 1; n <= 16; n++)
            sum = sum + 32'(decrypt ? SHIFT_DEC[5'(n)] : SHIFT_ENC[5'(n)]);
        return sum;
    endfunction

endpackage

// File: rtl/des_prims.sv
// Combinational DES building blocks: IP, IP^-1, PC1, PC2 and the f function.
module des_ip
    import des_pkg::*;
(
    input  logic [63:0] x,
    output logic [63:0] y
);
    always_comb begin
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    end
endmodule

module des_ip_inv
    import des_pkg::*;
(
    input  logic [63:0] x,
    output logic [63:0] y
);
    always_comb begin
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    end
endmodule

module des_pc1
    import des_pkg::*;
(
    input  logic [63:0] x,
    output logic [55:0] y
);
    always_comb begin
        y = '0;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
    end
endmodule

module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] x,
    output logic [47:0] y
);
    always_comb begin
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
    end
endmodule

module des_f
    import des_pkg::*;
(
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] y
);
    logic [47:0] e;
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  six;
    logic [63:0] row;

    // Expansion, key mix, S-box substitution, P permutation
    always_comb begin
        e = '0;
        for (int i = 0; i < 48; i++) e[6'(47 - i)] = r[5'(32 - E_T[6'(i)])];
        x   = e ^ k;
        s   = '0;
        six = '0;
        row = '0;
        for (int b = 0; b < 8; b++) begin
            six = x[6'(47 - 6 * b) -: 6];
            row = SBOX[{3'(b), six[5], six[0]}];
            s[5'(31 - 4 * b) -: 4] = row[6'(63 - 4 * int'(six[4:1])) -: 4];
        end
        y = '0;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[5'(i)])];
    end
endmodule

// File: rtl/des_round.sv
// One combinational Feistel round with its key-schedule rotation.
module des_round
    import des_pkg::*;
(
    input  logic [31:0] l,
    input  logic [31:0] r,
    input  logic [27:0] c,
    input  logic [27:0] d,
    input  logic [4:0]  round_idx,
    input  logic        decrypt,
    output logic [31:0] l_next,
    output logic [31:0] r_next,
    output logic [27:0] c_next,
    output logic [27:0] d_next
);
    logic [1:0]  amt;
    logic [47:0] key;
    logic [31:0] f_out;

    assign amt    = decrypt ? SHIFT_DEC[round_idx] : SHIFT_ENC[round_idx];
    assign c_next = rot28(c, amt, decrypt);
    assign d_next = rot28(d, amt, decrypt);

    des_pc2 u_pc2 (.x({c_next, d_next}), .y(key));
    des_f   u_f   (.r(r), .k(key), .y(f_out));

    assign l_next = r;
    assign r_next = l ^ f_out;
endmodule

// File: rtl/des_iter_core.sv
// Iterative handshaked DES engine running ROUNDS_PER_CYCLE Feistel rounds per clock.
module des_iter_core
    import des_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    input  logic        in_decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);
    localparam int unsigned NUM_STEPS = DES_ROUNDS / ROUNDS_PER_CYCLE;
    localparam int unsigned STEP_W    = 4;
    localparam int unsigned RPC       = ROUNDS_PER_CYCLE;

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
        $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
    // Encrypt rotations total 28 so C/D come back to PC1; decrypt totals 27 so its last key is K1
    if (shift_total(1'b0) != 28 || shift_total(1'b1) != 27) begin : g_bad_sched
        $error("des_iter_core: key schedule rotation totals are inconsistent");
    end

    state_t              state;
    logic [31:0]         l, r;
    logic [27:0]         c, d;
    logic [STEP_W-1:0]   step;
    logic                mode;
    logic                accept;
    logic [63:0]         ip_out, fp_out;
    logic [55:0]         pc1_out;

    logic [31:0] l_ch [RPC+1];
    logic [31:0] r_ch [RPC+1];
    logic [27:0] c_ch [RPC+1];
    logic [27:0] d_ch [RPC+1];

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    des_ip     u_ip  (.x(in_data), .y(ip_out));
    des_pc1    u_pc1 (.x(in_key), .y(pc1_out));
    des_ip_inv u_fp  (.x({r_ch[RPC], l_ch[RPC]}), .y(fp_out));

    assign l_ch[0] = l;
    assign r_ch[0] = r;
    assign c_ch[0] = c;
    assign d_ch[0] = d;

    for (genvar k = 0; k < RPC; k++) begin : g_round
        logic [4:0] idx;
        assign idx = 5'(32'(step) * RPC + k + 1);
        des_round u_round (
            .l(l_ch[k]), .r(r_ch[k]), .c(c_ch[k]), .d(d_ch[k]),
            .round_idx(idx), .decrypt(mode),
            .l_next(l_ch[k+1]), .r_next(r_ch[k+1]), .c_next(c_ch[k+1]), .d_next(d_ch[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            l         <= '0;
            r         <= '0;
            c         <= '0;
            d         <= '0;
            step      <= '0;
            mode      <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                RUN: begin
                    l    <= l_ch[RPC];
                    r    <= r_ch[RPC];
                    c    <= c_ch[RPC];
                    d    <= d_ch[RPC];
                    step <= step + STEP_W'(1);
                    if (step == STEP_W'(NUM_STEPS - 1)) begin
                        out_data  <= fp_out;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A new block may also be taken on the retiring edge of DONE
            if (accept) begin
                {l, r} <= ip_out;
                {c, d} <= pc1_out;
                mode   <= in_decrypt;
                step   <= '0;
                busy   <= 1'b1;
                state  <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_des_iter_core.sv
// Directed and random scoreboard bench for des_iter_core across all ROUNDS_PER_CYCLE values.
module tb_des_iter_core;

    typedef struct packed {
        logic [63:0] data;
        logic        chk;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_data;
    logic [63:0] in_key;
    logic        in_decrypt;
    logic        out_ready;
    logic [4:0]  in_ready_a;
    logic [4:0]  out_valid_a;
    logic [4:0]  busy_a;
    logic [63:0] out_data_a [5];

    int   cyc = 0;
    int   acc_cyc = 0;
    int   tests = 0;
    int   failures = 0;
    sb_t  sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        des_iter_core #(.ROUNDS_PER_CYCLE(1 << g)) dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid), .in_ready(in_ready_a[g]),
            .in_data(in_data), .in_key(in_key), .in_decrypt(in_decrypt),
            .out_valid(out_valid_a[g]), .out_ready(out_ready),
            .out_data(out_data_a[g]), .busy(busy_a[g])
        );
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one block to the main core once it is ready; inputs are scrambled afterwards
    task automatic send(input logic [63:0] key, input logic [63:0] data, input logic dec,
                        input logic [63:0] exp, input logic chk);
        int n = 0;
        @(negedge clk);
        while (!in_ready_a[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send ready", 72'(in_ready_a[0]), 72'(1));
        in_valid   = 1'b1;
        in_key     = key;
        in_data    = data;
        in_decrypt = dec;
        sb.push_back('{data: exp, chk: chk});
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        in_valid   = 1'b0;
        in_key     = {$urandom, $urandom};
        in_data    = {$urandom, $urandom};
        in_decrypt = 1'($urandom);
    endtask

    // Wait for the main core's result with random sink stalls; the held result must not move
    task automatic receive(input string tag, input int stall_pct, input int exp_lat,
                           output logic [63:0] got);
        sb_t         e;
        logic        seen = 1'b0;
        logic        done = 1'b0;
        logic [63:0] held = '0;
        int          n = 0;
        got = '0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
            if (seen) begin
                check({tag, " hold"}, 72'({out_valid_a[0], out_data_a[0]}), 72'({1'b1, held}));
            end else if (out_valid_a[0]) begin
                seen = 1'b1;
                held = out_data_a[0];
                if (exp_lat >= 0) check({tag, " latency"}, 72'(cyc - acc_cyc), 72'(exp_lat));
            end
            out_ready = ($urandom_range(99) >= 32'(stall_pct));
            if (seen && out_ready) begin
                e    = sb.pop_front();
                got  = out_data_a[0];
                done = 1'b1;
                if (e.chk) check(tag, 72'(out_data_a[0]), 72'(e.data));
            end
        end
        check({tag, " completed"}, 72'(done), 72'(1));
        if (!done && sb.size() > 0) void'(sb.pop_front());
        @(posedge clk);
    endtask

    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
    localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PT2  = 64'h8787878787878787;

    initial begin
        logic [63:0] got, ct, key, pt;
        logic [4:0]  seen2;
        sb_t         e;
        int          n;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_key = '0;
        in_decrypt = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            check("reset out_valid", 72'(out_valid_a[3'(g)]), 72'(0));
            check("reset busy", 72'(busy_a[3'(g)]), 72'(0));
            check("reset in_ready", 72'(in_ready_a[3'(g)]), 72'(1));
            check("reset out_data", 72'(out_data_a[3'(g)]), 72'(0));
        end
        rst = 1'b0;

        // Known-answer encrypt and decrypt
        send(KEY1, PT1, 1'b0, CT1, 1'b1);
        receive("vec1 enc", 0, 16, got);
        send(KEY1, CT1, 1'b1, PT1, 1'b1);
        receive("vec1 dec", 0, 16, got);

        // Every parallelism level on the second known answer
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_key = KEY2;
        in_data = PT2;
        in_decrypt = 1'b0;
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        seen2 = '0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            for (int g = 0; g < 5; g++) begin
                if (out_valid_a[3'(g)] && !seen2[3'(g)]) begin
                    seen2[3'(g)] = 1'b1;
                    check("vec2 latency", 72'(cyc - acc_cyc), 72'(16 >> g));
                    check("vec2 data", 72'(out_data_a[3'(g)]), 72'(0));
                end
            end
        end
        for (int g = 0; g < 5; g++) check("vec2 seen", 72'(seen2[3'(g)]), 72'(1));

        // Backpressure in DONE with a waiting block, then back-to-back accept
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_key = KEY1;
        in_data = PT1;
        in_decrypt = 1'b0;
        sb.push_back('{data: CT1, chk: 1'b1});
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid_a[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b first latency", 72'(cyc - acc_cyc), 72'(16));
        in_valid = 1'b1;
        in_data = CT1;
        in_decrypt = 1'b1;
        sb.push_back('{data: PT1, chk: 1'b1});
        repeat (5) begin
            check("stall out_valid", 72'(out_valid_a[0]), 72'(1));
            check("stall out_data", 72'(out_data_a[0]), 72'(CT1));
            check("stall in_ready", 72'(in_ready_a[0]), 72'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("b2b in_ready", 72'(in_ready_a[0]), 72'(1));
        e = sb.pop_front();
        check("b2b first data", 72'(out_data_a[0]), 72'(e.data));
        @(posedge clk);
        #1 acc_cyc = cyc;
        check("b2b out_valid drop", 72'(out_valid_a[0]), 72'(0));
        check("b2b busy", 72'(busy_a[0]), 72'(1));
        @(negedge clk);
        in_valid = 1'b0;
        receive("b2b second", 0, 16, got);

        // Reset while at step 7 of a serial run
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_key = KEY1;
        in_data = PT1;
        in_decrypt = 1'b0;
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        while (cyc < acc_cyc + 7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrun rst out_valid", 72'(out_valid_a[0]), 72'(0));
        check("midrun rst busy", 72'(busy_a[0]), 72'(0));
        check("midrun rst in_ready", 72'(in_ready_a[0]), 72'(1));
        rst = 1'b0;
        send(KEY1, PT1, 1'b0, CT1, 1'b1);
        receive("after rst", 0, 16, got);

        // Random encrypt/decrypt round trips under sink stalls
        for (int t = 0; t < 1000; t++) begin
            key = {$urandom, $urandom};
            pt  = {$urandom, $urandom};
            send(key, pt, 1'b0, 64'h0, 1'b0);
            receive("rt enc", 30, 16, ct);
            send(key, ct, 1'b1, pt, 1'b1);
            receive("rt dec", 30, 16, got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
